gestor_solicitudes: RTL and testbench

Upstream stage of the elevator algorithm FSM. It synchronises the 10 raw button inputs and latches each press into the request vector s[9:0], which the algorithm consumes. It clears requests once they are served and runs the door-open timer that drives the algorithm's esperar input. It reads back the algorithm's 4-bit state: [3] moving, [2] direction up, [1:0] floor 0..3.

---
 rtl/ascensor_pkg.sv | 60 ++++++
 rtl/sincronizador_botones.sv | 49 ++++
 rtl/gestor_solicitudes.sv | 99 +++++++++
 tb/tb_gestor_solicitudes.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascensor_pkg.sv
// Shared definitions between the request manager and the elevator algorithm FSM:
// request bit map, estado field positions, door states and served-request masks.
package ascensor_pkg;

    localparam int NUM_BOTONES = 10;

    localparam int LLAMA_P1  = 0;
    localparam int BAJA_P2   = 1;
    localparam int SUBE_P2   = 2;
    localparam int BAJA_P3   = 3;
    localparam int SUBE_P3   = 4;
    localparam int LLAMA_P4  = 5;
    localparam int CABINA_P1 = 6;
    localparam int CABINA_P2 = 7;
    localparam int CABINA_P3 = 8;
    localparam int CABINA_P4 = 9;

    localparam int EST_MOV      = 3;
    localparam int EST_DIR      = 2;
    localparam int EST_PISO_MSB = 1;
    localparam int EST_PISO_LSB = 0;

    typedef enum logic {
        CERRADA = 1'b0,
        ABIERTA = 1'b1
    } puerta_t;

    // Requests satisfied by stopping at floor f while travelling in direction dir.
    function automatic logic [NUM_BOTONES-1:0] mascara_servida(input logic [1:0] f,
                                                               input logic       dir);
        logic [NUM_BOTONES-1:0] m;
        m = '0;
        case (f)
            2'd0: begin
                m[CABINA_P1] = 1'b1;
                m[LLAMA_P1]  = 1'b1;
            end
            2'd1: begin
                m[CABINA_P2] = 1'b1;
                if (dir) m[SUBE_P2] = 1'b1;
                else     m[BAJA_P2] = 1'b1;
            end
            2'd2: begin
                m[CABINA_P3] = 1'b1;
                if (dir) m[SUBE_P3] = 1'b1;
                else     m[BAJA_P3] = 1'b1;
            end
            default: begin
                m[CABINA_P4] = 1'b1;
                m[LLAMA_P4]  = 1'b1;
            end
        endcase
        return m;
    endfunction

    function automatic logic [NUM_BOTONES-1:0] mascara_piso(input logic [1:0] f);
        return mascara_servida(f, 1'b0) | mascara_servida(f, 1'b1);
    endfunction

endpackage

// File: rtl/sincronizador_botones.sv
// Two-flop synchroniser plus rising-edge detect; emits one registered pulse per press.
// Edge sampled at clock n gives a pulse after edge n+2; edges in the first cycles after reset are masked.
module sincronizador_botones #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] botones_i,
    output logic [N-1:0] pulso_o
);

    logic [N-1:0] sinc1_q, sinc1_d;
    logic [N-1:0] sinc2_q, sinc2_d;
    logic [N-1:0] prev_q,  prev_d;
    logic [N-1:0] pulso_q, pulso_d;
    logic [1:0]   arm_q,   arm_d;
    logic         armado;

    // Until prev_q holds a genuinely sampled level, a button held through reset
    // would look like a rising edge; those comparisons are suppressed.
    assign armado = (arm_q == 2'd3);

    always_comb begin
        sinc1_d = botones_i;
        sinc2_d = sinc1_q;
        prev_d  = sinc2_q;
        arm_d   = armado ? arm_q : arm_q + 2'd1;
        pulso_d = armado ? (sinc2_q & ~prev_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc1_q <= '0;
            sinc2_q <= '0;
            prev_q  <= '0;
            pulso_q <= '0;
            arm_q   <= '0;
        end else begin
            sinc1_q <= sinc1_d;
            sinc2_q <= sinc2_d;
            prev_q  <= prev_d;
            pulso_q <= pulso_d;
            arm_q   <= arm_d;
        end
    end

    assign pulso_o = pulso_q;

endmodule

// File: rtl/gestor_solicitudes.sv
// Latches button presses into the request vector, clears served requests and runs the door timer.
// Press sampled at edge n appears in s after edge n+3; esperar rises the cycle after the open decision.
module gestor_solicitudes
    import ascensor_pkg::*;
#(
    parameter int T_PUERTA = 50,
    parameter int CNT_W    = $clog2(T_PUERTA)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BOTONES-1:0] botones,
    input  logic [3:0]             estado,
    input  logic                   obstruida,
    output logic [NUM_BOTONES-1:0] s,
    output logic                   esperar
);

    localparam logic [CNT_W-1:0] CNT_RECARGA = CNT_W'(T_PUERTA - 1);

    logic [NUM_BOTONES-1:0] pulso;

    puerta_t                puerta_q, puerta_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [NUM_BOTONES-1:0] s_q,      s_d;
    logic                   prev_mov_q, prev_mov_d;

    logic [NUM_BOTONES-1:0] m_serv;
    logic [NUM_BOTONES-1:0] m_piso;
    logic [NUM_BOTONES-1:0] limpiar;
    logic                   moviendo;
    logic                   llegada;

    sincronizador_botones #(
        .N (NUM_BOTONES)
    ) u_sinc (
        .clk       (clk),
        .rst       (reset),
        .botones_i (botones),
        .pulso_o   (pulso)
    );

    assign moviendo = estado[EST_MOV];
    assign llegada  = prev_mov_q & ~moviendo;
    assign m_serv   = mascara_servida(estado[EST_PISO_MSB:EST_PISO_LSB], estado[EST_DIR]);
    assign m_piso   = mascara_piso(estado[EST_PISO_MSB:EST_PISO_LSB]);

    always_comb begin
        puerta_d   = puerta_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        limpiar    = '0;
        prev_mov_d = moviendo;

        case (puerta_q)
            CERRADA: begin
                // Arrival wins over the idle-floor rule; the idle rule also covers reversal.
                if (llegada) begin
                    limpiar  = m_serv;
                    puerta_d = ABIERTA;
                    cnt_d    = CNT_RECARGA;
                end else if (!moviendo && |(s_q & m_piso)) begin
                    limpiar  = m_piso;
                    puerta_d = ABIERTA;
                    cnt_d    = CNT_RECARGA;
                end
                s_d = (s_q | pulso) & ~limpiar;
            end
            ABIERTA: begin
                // Presses for the current floor are absorbed as a door-hold request.
                s_d = s_q | (pulso & ~m_piso);
                if (|(pulso & m_piso) || obstruida) begin
                    cnt_d = CNT_RECARGA;
                end else if (cnt_q == '0) begin
                    puerta_d = CERRADA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            puerta_q   <= CERRADA;
            cnt_q      <= '0;
            s_q        <= '0;
            prev_mov_q <= 1'b0;
        end else begin
            puerta_q   <= puerta_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            prev_mov_q <= prev_mov_d;
        end
    end

    assign s       = s_q;
    assign esperar = (puerta_q == ABIERTA);

endmodule

// File: tb/tb_gestor_solicitudes.sv
// Directed bench for gestor_solicitudes with a request-level reference model checked every cycle.
module tb_gestor_solicitudes;

    localparam int T = 4;

    logic       clk;
    logic       reset;
    logic [9:0] botones;
    logic [3:0] estado;
    logic       obstruida;
    logic [9:0] s;
    logic       esperar;

    int n_cmp = 0;
    int n_bad = 0;

    gestor_solicitudes #(
        .T_PUERTA (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .botones   (botones),
        .estado    (estado),
        .obstruida (obstruida),
        .s         (s),
        .esperar   (esperar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [9:0] m_s = '0;
    bit         m_abierta = 1'b0;
    int         m_rest = 0;
    bit         m_prev_mov = 1'b0;
    logic [9:0] m_ult_muestra = '0;
    int         m_nmuestras = 0;
    logic [9:0] m_retardo[$];
    int         sube_idx[4] = '{0, 2, 4, 5};
    int         baja_idx[4] = '{0, 1, 3, 5};

    task automatic modelo_reset();
        m_s           = '0;
        m_abierta     = 1'b0;
        m_rest        = 0;
        m_prev_mov    = 1'b0;
        m_ult_muestra = '0;
        m_nmuestras   = 0;
        m_retardo.delete();
    endtask

    task automatic modelo_paso();
        logic [9:0] p, serv, piso_m, nueva;
        int         f;
        bit         mov, dir;
        nueva = (m_nmuestras > 0) ? (botones & ~m_ult_muestra) : 10'h000;
        m_ult_muestra = botones;
        m_nmuestras++;
        m_retardo.push_back(nueva);
        p = 10'h000;
        if (m_retardo.size() > 3) p = m_retardo.pop_front();
        f   = int'(estado[1:0]);
        dir = estado[2];
        mov = estado[3];
        serv = 10'h000;
        serv[6 + f] = 1'b1;
        serv[dir ? sube_idx[f] : baja_idx[f]] = 1'b1;
        piso_m = serv;
        piso_m[sube_idx[f]] = 1'b1;
        piso_m[baja_idx[f]] = 1'b1;
        if (!m_abierta) begin
            if (m_prev_mov && !mov) begin
                m_s = (m_s | p) & ~serv;
                m_abierta = 1'b1;
                m_rest = T - 1;
            end else if (!mov && (m_s & piso_m) != 10'h000) begin
                m_s = (m_s | p) & ~piso_m;
                m_abierta = 1'b1;
                m_rest = T - 1;
            end else begin
                m_s = m_s | p;
            end
        end else begin
            m_s = m_s | (p & ~piso_m);
            if ((p & piso_m) != 10'h000 || obstruida) m_rest = T - 1;
            else if (m_rest == 0) m_abierta = 1'b0;
            else m_rest--;
        end
        m_prev_mov = mov;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelo_reset();
            else modelo_paso();
        end
    end

    // ---------------- checking ----------------
    task automatic chequear(input string nombre, input logic [9:0] act, input logic [9:0] esp);
        n_cmp++;
        if (act !== esp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nombre, act, esp, $time);
        end
    endtask

    int racha = 0;
    int ultimo_abierto = 0;

    initial begin
        forever begin
            @(negedge clk);
            chequear("model_s", s, m_s);
            chequear("model_esperar", {9'b0, esperar}, {9'b0, m_abierta});
            if (esperar === 1'b1) begin
                racha++;
            end else if (racha > 0) begin
                ultimo_abierto = racha;
                racha = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic esperar_cierre();
        int k;
        k = 0;
        while (esperar === 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        chequear("door_close_timeout", {9'b0, esperar}, 10'h000);
    endtask

    task automatic llegar_p2_subiendo();
        estado = 4'b1101;
        tick(2);
        estado = 4'b0101;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset     = 1'b0;
        botones   = 10'h3FF;
        estado    = 4'b0000;
        obstruida = 1'b0;
        #2 reset = 1'b1;
        tick(3);
        chequear("reset_s", s, 10'h000);
        chequear("reset_esperar", {9'b0, esperar}, 10'h000);
        reset = 1'b0;
        tick(6);
        chequear("held_no_press", s, 10'h000);
        botones = 10'h000;
        tick(3);

        // single press on cabin floor 3: visible three edges after sampling
        botones = 10'h100;
        tick(1);
        botones = 10'h000;
        tick(2);
        chequear("press_latency_early", s, 10'h000);
        tick(1);
        chequear("press_latency", s, 10'h100);

        // idle at floor index 2: pending cabin request opens the door
        estado = 4'b0010;
        tick(1);
        chequear("idle_clear_s", s, 10'h000);
        chequear("idle_open", {9'b0, esperar}, 10'h001);
        esperar_cierre();
        chequear("idle_open_len", 10'(ultimo_abierto), 10'd4);

        // moving up past floor index 1, then arrival clears up-call only
        estado  = 4'b1101;
        botones = 10'h014;
        tick(1);
        botones = 10'h000;
        tick(3);
        chequear("moving_latch", s, 10'h014);
        estado = 4'b0101;
        tick(1);
        chequear("arrival_clear", s, 10'h010);
        chequear("arrival_open", {9'b0, esperar}, 10'h001);
        esperar_cierre();
        chequear("arrival_open_len", 10'(ultimo_abierto), 10'd4);

        // direction reversal: stopped heading down, up-call at the same floor
        estado  = 4'b0001;
        botones = 10'h004;
        tick(1);
        botones = 10'h000;
        tick(3);
        chequear("reversal_transient", s, 10'h014);
        tick(1);
        chequear("reversal_clear", s, 10'h010);
        esperar_cierre();
        chequear("reversal_open_len", 10'(ultimo_abierto), 10'd4);

        // absorbed cabin press at counter==1 reloads; other-floor press only latches
        llegar_p2_subiendo();
        botones = 10'h080;
        tick(1);
        botones = 10'h000;
        chequear("absorb_open", {9'b0, esperar}, 10'h001);
        tick(3);
        botones = 10'h200;
        tick(1);
        botones = 10'h000;
        esperar_cierre();
        chequear("absorb_open_len", 10'(ultimo_abierto), 10'd7);
        chequear("absorb_s", s, 10'h210);

        // obstruction holds the door, then a full dwell after it clears
        llegar_p2_subiendo();
        tick(1);
        obstruida = 1'b1;
        tick(10);
        chequear("obstruct_hold", {9'b0, esperar}, 10'h001);
        obstruida = 1'b0;
        esperar_cierre();
        chequear("obstruct_open_len", 10'(ultimo_abierto), 10'd14);

        // reset in the middle of an open door with pending requests
        botones = 10'h001;
        tick(1);
        botones = 10'h000;
        tick(4);
        chequear("pending_before_reset", s, 10'h211);
        llegar_p2_subiendo();
        tick(1);
        chequear("open_before_reset", {9'b0, esperar}, 10'h001);
        botones = 10'h3FF;
        reset   = 1'b1;
        #1;
        chequear("async_reset_s", s, 10'h000);
        chequear("async_reset_esperar", {9'b0, esperar}, 10'h000);
        tick(2);
        reset = 1'b0;
        tick(10);
        chequear("post_reset_held_s", s, 10'h000);
        chequear("post_reset_closed", {9'b0, esperar}, 10'h000);
        botones = 10'h000;
        tick(5);
        chequear("post_reset_release_s", s, 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
